// File: rtl/commit_trace_buf.sv
// Commit-stream capture FIFO with sequence stamping and drop accounting.
// Optional COMMIT_TRACE_X0_FILTER_EN discards commits that write x0.
module commit_trace_buf #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_data,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_data,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic [SEQ_W-1:0]         drop_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 32 + 5 + 32 + SEQ_W;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;

  logic pass, cand, pop, push, drop, wr_en;
  logic [EW-1:0] head;

  always_comb begin
`ifdef COMMIT_TRACE_X0_FILTER_EN
    pass = (commit_rd != 5'd0);
`else
    pass = 1'b1;
`endif
    cand  = commit_valid & pass;
    pop   = (level_q != '0) & out_ready;
    // A pop in the same cycle frees the slot the push needs.
    push  = cand & ((level_q != FULL) | pop);
    drop  = cand & ~push;
    wr_en = push & ~clear;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      seq_d    = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (cand) seq_d    = seq_q + 1'b1;
      if (push && !pop) level_d = level_q + 1'b1;
      if (pop && !push) level_d = level_q - 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q] <= {commit_pc, commit_rd, commit_data, seq_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (level_q != '0);
  assign out_pc     = head[EW-1 -: 32];
  assign out_rd     = head[SEQ_W+32 +: 5];
  assign out_data   = head[SEQ_W +: 32];
  assign out_seq    = head[SEQ_W-1:0];
  assign level      = level_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf (DEPTH=16, SEQ_W=16).
module tb_commit_trace_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  logic [15:0] out_seq;
  logic [4:0]  level;
  logic [15:0] drop_count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  commit_trace_buf #(.DEPTH(16), .SEQ_W(16)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data),
    .out_seq(out_seq), .level(level),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_commit(input logic [31:0] pc,
                           input logic [4:0] rd,
                           input logic [31:0] data);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_rd    = rd;
    commit_data  = data;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    commit_valid = 1'b0;
    commit_pc = '0;
    commit_rd = '0;
    commit_data = '0;
    clear = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    #3 reset = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    n_cmp++;
    if (level !== 5'd0) begin
      n_err++; $display("FAIL reset_level: got %0d want 0", level);
    end
    n_cmp++;
    if (drop_count !== 16'd0) begin
      n_err++; $display("FAIL reset_drop: got %0d want 0", drop_count);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL reset_ovf: got %0b want 0", overflow);
    end
  endtask

  task automatic test_single();
    do_commit(32'h100, 5'd4, 32'd7);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL single_valid: got %0b want 1", out_valid);
    end
    n_cmp++;
    if (out_pc !== 32'h100 || out_rd !== 5'd4 || out_data !== 32'd7) begin
      n_err++;
      $display("FAIL single_fields: got pc=%0h rd=%0d data=%0d want 100/4/7",
               out_pc, out_rd, out_data);
    end
    n_cmp++;
    if (out_seq !== 16'd0 || level !== 5'd1) begin
      n_err++;
      $display("FAIL single_seq_lvl: got seq=%0d lvl=%0d want 0/1",
               out_seq, level);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pop: got lvl=%0d valid=%0b want 0/0",
               level, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int rx;
    rx = 0;
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 45; i++) begin
      if (i < 40) begin
        commit_valid = 1'b1;
        commit_pc    = 32'h1000 + 32'(i * 4);
        commit_rd    = 5'((i % 31) + 1);
        commit_data  = 32'(i);
      end else begin
        commit_valid = 1'b0;
      end
      if (out_valid) begin
        n_cmp++;
        if (out_seq !== 16'(rx) || out_pc !== 32'h1000 + 32'(rx * 4)) begin
          n_err++;
          $display("FAIL b2b_order: got seq=%0d pc=%0h want %0d/%0h",
                   out_seq, out_pc, rx, 32'h1000 + 32'(rx * 4));
        end
        rx++;
      end
      tick();
      n_cmp++;
      if (level > 5'd1) begin
        n_err++; $display("FAIL b2b_level: got %0d want <=1", level);
      end
    end
    out_ready = 1'b0;
    n_cmp++;
    if (rx != 40) begin
      n_err++; $display("FAIL b2b_count: got %0d want 40", rx);
    end
    n_cmp++;
    if (drop_count !== 16'd0) begin
      n_err++; $display("FAIL b2b_drop: got %0d want 0", drop_count);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      do_commit(32'h2000 + 32'(i), 5'd1, 32'(i));
    n_cmp++;
    if (level !== 5'd16) begin
      n_err++; $display("FAIL ovf_level: got %0d want 16", level);
    end
    n_cmp++;
    if (drop_count !== 16'd4 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drop: got drop=%0d ovf=%0b want 4/1",
               drop_count, overflow);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_seq !== 16'(k)) begin
        n_err++;
        $display("FAIL ovf_drain: got valid=%0b seq=%0d want 1/%0d",
                 out_valid, out_seq, k);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL ovf_empty: got %0b want 0", out_valid);
    end
    do_commit(32'h3000, 5'd2, 32'd9);
    n_cmp++;
    if (out_seq !== 16'd20 || level !== 5'd1) begin
      n_err++;
      $display("FAIL ovf_next_seq: got seq=%0d lvl=%0d want 20/1",
               out_seq, level);
    end
  endtask

  task automatic test_full_simul();
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++)
      do_commit(32'h4000 + 32'(i), 5'd3, 32'(i));
    n_cmp++;
    if (level !== 5'd16 || out_seq !== 16'd0) begin
      n_err++;
      $display("FAIL full_pre: got lvl=%0d seq=%0d want 16/0", level, out_seq);
    end
    out_ready = 1'b1;
    do_commit(32'h4100, 5'd3, 32'd99);
    out_ready = 1'b0;
    n_cmp++;
    if (level !== 5'd16 || drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL full_simul: got lvl=%0d drop=%0d want 16/0",
               level, drop_count);
    end
    n_cmp++;
    if (out_seq !== 16'd1 || out_pc !== 32'h4001) begin
      n_err++;
      $display("FAIL full_head: got seq=%0d pc=%0h want 1/4001",
               out_seq, out_pc);
    end
  endtask

  task automatic test_reset_clear_mid();
    do_clear();
    for (int i = 0; i < 5; i++)
      do_commit(32'h5000 + 32'(i), 5'd6, 32'(i));
    n_cmp++;
    if (level !== 5'd5) begin
      n_err++; $display("FAIL mid_pre: got %0d want 5", level);
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%0b lvl=%0d want 0/0",
               out_valid, level);
    end
    #2 reset = 1'b0;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++)
      do_commit(32'h6000 + 32'(i), 5'd7, 32'(i));
    n_cmp++;
    if (level !== 5'd16 || drop_count !== 16'd1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clr_pre: got lvl=%0d drop=%0d ovf=%0b want 16/1/1",
               level, drop_count, overflow);
    end
    clear = 1'b1;
    commit_valid = 1'b1;
    commit_rd = 5'd7;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    commit_valid = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || level !== 5'd0 ||
        drop_count !== 16'd0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear: got valid=%0b lvl=%0d drop=%0d ovf=%0b want 0s",
               out_valid, level, drop_count, overflow);
    end
    do_commit(32'h7000, 5'd9, 32'd1);
    n_cmp++;
    if (out_seq !== 16'd0 || out_pc !== 32'h7000) begin
      n_err++;
      $display("FAIL clear_seq: got seq=%0d pc=%0h want 0/7000",
               out_seq, out_pc);
    end
  endtask

  task automatic test_filter();
    logic [4:0] rds [4];
    logic [4:0] exp_rd [4];
    int n_exp;
    rds[0] = 5'd0; rds[1] = 5'd3; rds[2] = 5'd0; rds[3] = 5'd5;
`ifdef COMMIT_TRACE_X0_FILTER_EN
    n_exp = 2;
    exp_rd[0] = 5'd3; exp_rd[1] = 5'd5; exp_rd[2] = 5'd0; exp_rd[3] = 5'd0;
`else
    n_exp = 4;
    exp_rd = rds;
`endif
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      do_commit(32'h8000 + 32'(i), rds[i], 32'(i));
    n_cmp++;
    if (level !== 5'(n_exp)) begin
      n_err++; $display("FAIL filter_level: got %0d want %0d", level, n_exp);
    end
    out_ready = 1'b1;
    for (int k = 0; k < n_exp; k++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_seq !== 16'(k) || out_rd !== exp_rd[k]) begin
        n_err++;
        $display("FAIL filter_entry: got valid=%0b seq=%0d rd=%0d want 1/%0d/%0d",
                 out_valid, out_seq, out_rd, k, exp_rd[k]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || drop_count !== 16'd0) begin
      n_err++;
      $display("FAIL filter_end: got valid=%0b drop=%0d want 0/0",
               out_valid, drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_simul();
    test_reset_clear_mid();
    test_filter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/commit_trace_buf.md
# commit_trace_buf

Capture buffer for the core's retirement (commit) stream. Sits on the consumer side of the debug commit port (`commit_valid/commit_pc/commit_rd/commit_data`). It timestamps each commit with a sequence number, queues it in a FIFO, and presents it to a downstream reader (trace dumper, UVM monitor bridge, or log serializer) over a valid/ready handshake. Overflow is never silent: dropped commits are counted, and each drop leaves a gap in the sequence numbers.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `SEQ_W`, 16: width of the sequence number and the drop counter.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `commit_valid`  in  1  one commit retiring this cycle.
- `commit_pc`  in  32  PC of the retiring instruction.
- `commit_rd`  in  5  destination register.
- `commit_data`  in  32  value written to `rd`.
- `clear`  in  1  synchronous flush; same effect as reset, one cycle.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  reader accepts the head entry.
- `out_pc`  out  32  head PC.
- `out_rd`  out  5  head rd.
- `out_data`  out  32  head data.
- `out_seq`  out  SEQ_W  head sequence number.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `drop_count`  out  SEQ_W  commits lost to a full FIFO; saturating.
- `overflow`  out  1  sticky; set on the first drop.

## Operation
- Sequence counter `seq` starts at 0. It increments by 1 (wrapping modulo 2^SEQ_W) for every commit that is counted, whether stored or dropped.
- Push condition: `commit_valid` and the commit passes the filter (see Configuration).
  - The entry {pc, rd, data, seq} is written at `wr_ptr` if `level < DEPTH`, or if a pop happens in the same cycle (`out_valid && out_ready`).
  - Otherwise the commit is dropped: `drop_count` increments (saturating at all-ones) and `overflow` is set.
- Pop condition: `out_valid && out_ready`. `rd_ptr` advances.
- FIFO is first-word-fall-through. `out_*` reflect `mem[rd_ptr]` whenever `out_valid`. `out_valid` = (`level != 0`).
- When `out_valid` = 0, `out_pc/rd/data/seq` must not be relied upon; the bench does not check them.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `level` is a separate counter:
  - +1 on push only;
  - −1 on pop only;
  - unchanged when a push and a pop occur in the same cycle.
- `out_ready` while empty has no effect. A push into an empty FIFO is not visible at the output in the same cycle (no bypass).
- `clear` (sync), when high:
  - `level`, `wr_ptr`, `rd_ptr`, `seq`, `drop_count` and `overflow` go to 0.
  - Any commit or pop in that cycle is ignored.
- Reset values: `out_valid`=0, `level`=0, `drop_count`=0, `overflow`=0, `seq`=0, both pointers 0. Memory contents are not reset.
- `reset` asserted mid-operation empties the buffer immediately (asynchronous). Entries queued at that point are lost and are not counted as drops.

## Timing
- Latency: a commit accepted on edge N gives `out_valid`=1 and head fields valid after edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- Full case: `level`=DEPTH with a simultaneous commit and pop → the commit is accepted; `level` stays at DEPTH and nothing is dropped.
- Handshake:
  - Once `out_valid` is asserted, `out_*` stay stable until popped or cleared.
  - The reader may hold `out_ready` high continuously.
- `drop_count`, `overflow` and `level` are registered; they update on the edge that performs the event.

## Configuration
- Macro `COMMIT_TRACE_X0_FILTER_EN`.
- Defined: commits with `commit_rd == 0` are discarded before the push logic. They are not stored, do not advance `seq`, and do not count as drops.
- Undefined: every `commit_valid` cycle is a candidate push, including writes to x0.

## Test plan
- Single commit: reset, then one commit {pc=0x100, rd=4, data=7}. Expect `out_valid`=1 next cycle with `out_pc`=0x100, `out_rd`=4, `out_data`=7, `out_seq`=0, `level`=1. Pulse `out_ready` → `level`=0, `out_valid`=0.
- Back-to-back stream: 40 commits on consecutive cycles, `out_ready` held at 1, DEPTH=16. Expect all 40 received in order with seq 0..39, `drop_count`=0, and `level` never above 1.
- Overflow: `out_ready`=0 while 20 commits are sent. Expect `level`=16, `drop_count`=4, `overflow`=1. Drain all entries → seq 0..15; a subsequent commit carries seq 20.
- Full + simultaneous: with `level`=16, drive a commit and `out_ready`=1 in the same cycle. Expect `level` stays 16, `drop_count` unchanged, and the head seq advances by 1.
- Reset/clear mid-stream: with `level`=5, assert `reset` asynchronously between edges. Expect `out_valid`=0 and `level`=0 immediately. Repeat using `clear` → outputs zero after the edge, and the next commit carries seq 0.
- Filter: send commits with rd=0, 3, 0, 5.
  - With `COMMIT_TRACE_X0_FILTER_EN`: only rd=3 (seq 0) and rd=5 (seq 1) appear.
  - Without it: four entries with seq 0..3.
